aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Sequencer for AES-128 key expansion. It accepts a 128-bit cipher key and
//  streams round keys 0..NUM_ROUNDS, one per handshake, over a valid/ready port.
//  It drives the shared SubWord and AddRcon combinational blocks through
//  dedicated ports and holds the current 4-word round key in a register.
//  It sits between key load and the round pipeline.
// PARAMETERS
//  NUM_ROUNDS  10  last round-key index emitted; legal 1..10 (AddRcon covers idx 0..9)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    1-cycle request; samples key_in; honoured only in IDLE
//  abort      in   1    cancel expansion; return to IDLE
//  key_in     in   128  cipher key, word0 = [127:96]
//  rk_valid   out  1    round_key holds a valid key
//  rk_ready   in   1    consumer accepts round_key
//  round_key  out  128  current round key {w0,w1,w2,w3}
//  rk_index   out  4    index of round_key, 0..NUM_ROUNDS
//  busy       out  1    high in ACTIVE
//  done       out  1    1-cycle pulse after the last key is accepted
//  sw_out     out  32   RotWord(w3) = {w3[23:0],w3[31:24]}, to SubWord
//  sw_in      in   32   SubWord(sw_out), combinational return
//  rc_index   out  4    = rk_index, to AddRcon round_index
//  rc_data    out  32   = sw_in, to AddRcon in_data
//  rc_xored   in   32   AddRcon result (temp word)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, round_key=0, rk_index=0, rk_valid=0,
//   busy=0, done=0. All outputs are registered except sw_out, rc_index and
//   rc_data, which are pure combinational functions of the registers.
//  Next-key math (combinational, 32-bit XOR, no carries):
//   t = rc_xored
//   n0 = w0^t;  n1 = w1^n0;  n2 = w2^n1;  n3 = w3^n2
//  FSM IDLE:
//   start=1 -> round_key<=key_in, rk_index<=0, rk_valid<=1, busy<=1, go ACTIVE.
//   Key 0 is valid the cycle after start (latency 1).
//  FSM ACTIVE:
//   No handshake (rk_valid & ~rk_ready) -> hold all outputs stable.
//   Handshake with rk_index<NUM_ROUNDS -> round_key<={n0,n1,n2,n3},
//    rk_index+1, rk_valid stays 1. No bubbles: a key on every cycle with ready=1.
//   Handshake with rk_index==NUM_ROUNDS -> rk_valid<=0, busy<=0, done<=1 for
//    1 cycle, go IDLE. round_key and rk_index keep their last values.
//  Priorities and corner cases:
//   abort, in any state -> rk_valid<=0, busy<=0, go IDLE next edge; no done
//    pulse; overrides a same-cycle handshake and a same-cycle start.
//   start while ACTIVE -> ignored; key_in is not sampled.
//   start on the same edge done is set -> honoured (state is already IDLE).
//   rk_index never passes NUM_ROUNDS and never wraps.
//   rst_n asserted mid-expansion -> immediate reset values; no done pulse.
// TESTING
//  FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> rk0=key,
//   rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6,
//   11 consecutive valid cycles, done 1 cycle after rk10.
//  Same key, ready toggled pseudo-randomly -> identical key sequence; round_key
//   and rk_index stable while valid&~ready.
//  Key all-zero -> rk1=62636363626363636263636362636363.
//  abort asserted with rk_index=4 -> rk_valid=0, busy=0 next cycle; no done; a
//   fresh start then yields rk0=key_in.
//  start pulsed at rk_index=3 with a different key_in -> ignored; sequence
//   continues with the original key.
//  rst_n pulled low at rk_index=7, asynchronously -> all outputs zero before the
//   next clk edge; start after release behaves as from power-up.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: loads a cipher key and streams round keys
// 0..NUM_ROUNDS over a valid/ready port, using external SubWord/AddRcon logic.
module aes_key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done,
  output logic [31:0]  sw_out,
  input  logic [31:0]  sw_in,
  output logic [3:0]   rc_index,
  output logic [31:0]  rc_data,
  input  logic [31:0]  rc_xored
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [127:0]   round_key_r, round_key_s;
  logic [3:0]     rk_index_r, rk_index_s;
  logic           rk_valid_r, rk_valid_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           hs_s;
  logic           last_s;
  logic [31:0]    w0_s, w1_s, w2_s, w3_s;
  logic [31:0]    n0_s, n1_s, n2_s, n3_s;

  assign w0_s = round_key_r[127:96];
  assign w1_s = round_key_r[95:64];
  assign w2_s = round_key_r[63:32];
  assign w3_s = round_key_r[31:0];

  // The temp word comes back from SubWord -> AddRcon; the rest is an XOR chain.
  assign n0_s = w0_s ^ rc_xored;
  assign n1_s = w1_s ^ n0_s;
  assign n2_s = w2_s ^ n1_s;
  assign n3_s = w3_s ^ n2_s;

  assign sw_out   = {w3_s[23:0], w3_s[31:24]};
  assign rc_index = rk_index_r;
  assign rc_data  = sw_in;

  assign hs_s   = rk_valid_r & rk_ready;
  assign last_s = (rk_index_r == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort wins over start and over a handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (start) begin
          state_s = ST_ACTIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (hs_s && last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    round_key_s = round_key_r;
    rk_index_s  = rk_index_r;
    rk_valid_s  = rk_valid_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          rk_valid_s = 1'b0;
          busy_s     = 1'b0;
        end else if (start) begin
          round_key_s = key_in;
          rk_index_s  = 4'd0;
          rk_valid_s  = 1'b1;
          busy_s      = 1'b1;
        end else begin
          rk_valid_s = 1'b0;
          busy_s     = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (abort) begin
          rk_valid_s = 1'b0;
          busy_s     = 1'b0;
        end else if (hs_s && last_s) begin
          rk_valid_s = 1'b0;
          busy_s     = 1'b0;
          done_s     = 1'b1;
        end else if (hs_s) begin
          round_key_s = {n0_s, n1_s, n2_s, n3_s};
          rk_index_s  = rk_index_r + 4'd1;
        end else begin
          round_key_s = round_key_r;
        end
      end
      default: begin
        rk_valid_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key_r <= 128'd0;
      rk_index_r  <= 4'd0;
      rk_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      round_key_r <= round_key_s;
      rk_index_r  <= rk_index_s;
      rk_valid_r  <= rk_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign round_key = round_key_r;
  assign rk_index  = rk_index_r;
  assign rk_valid  = rk_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl; supplies SubWord/AddRcon models and
// checks round keys against the FIPS-197 expansion.
module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;
  logic [31:0]  sw_out;
  logic [31:0]  sw_in;
  logic [3:0]   rc_index;
  logic [31:0]  rc_data;
  logic [31:0]  rc_xored;

  int checks;
  int errors;

  logic [127:0] fips_rk [11];
  logic [127:0] fips_key;
  logic [127:0] zero_rk1;

  aes_key_sched_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
    .rk_index(rk_index), .busy(busy), .done(done), .sw_out(sw_out),
    .sw_in(sw_in), .rc_index(rc_index), .rc_data(rc_data), .rc_xored(rc_xored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] sbox_row(input logic [3:0] hi);
    case (hi)
      4'h0: sbox_row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: sbox_row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: sbox_row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: sbox_row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: sbox_row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: sbox_row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: sbox_row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: sbox_row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: sbox_row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: sbox_row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: sbox_row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: sbox_row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: sbox_row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: sbox_row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: sbox_row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: sbox_row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = sbox_row(b[7:4]);
    sbox = row[(15 - int'(b[3:0])) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0: rcon = 8'h01;  4'd1: rcon = 8'h02;  4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;  4'd4: rcon = 8'h10;  4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;  4'd7: rcon = 8'h80;  4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign sw_in    = sub_word(sw_out);
  assign rc_xored = rc_data ^ {rcon(rc_index), 24'h000000};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    step();
    start  = 1'b0;
  endtask

  task automatic go_idle;
    rk_ready = 1'b0;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = 128'd0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({rk_valid, busy, done, rk_index, round_key} !== 135'd0) begin
      errors++;
      $display("FAIL reset: v=%0b b=%0b d=%0b idx=%0d rk=%h, required all zero",
               rk_valid, busy, done, rk_index, round_key);
    end
  endtask

  task automatic test_fips_ready;
    rk_ready = 1'b1;
    do_start(fips_key);
    checks++;
    if (sw_out !== 32'hcf4f3c09) begin
      errors++; $display("FAIL sw_out_rot: got %h required cf4f3c09", sw_out);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || round_key !== fips_rk[i] ||
          rk_index !== 4'(i) || rc_index !== 4'(i)) begin
        errors++;
        $display("FAIL fips_rk%0d: v=%0b b=%0b idx=%0d rk=%h, required v=1 b=1 idx=%0d rk=%h",
                 i, rk_valid, busy, rk_index, round_key, i, fips_rk[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 ||
        rk_index !== 4'd10 || round_key !== fips_rk[10]) begin
      errors++;
      $display("FAIL fips_done: d=%0b v=%0b b=%0b idx=%0d, required d=1 v=0 b=0 idx=10",
               done, rk_valid, busy, rk_index);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL fips_done_pulse: done=%0b required 0", done);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] pat;
    int exp_idx;
    bit fin;
    logic rdy;
    pat = 32'h9b3da5c6;
    exp_idx = 0;
    fin = 1'b0;
    rk_ready = 1'b0;
    do_start(fips_key);
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      checks++;
      if (rk_valid !== 1'b1 || round_key !== fips_rk[exp_idx] || rk_index !== 4'(exp_idx)) begin
        errors++;
        $display("FAIL bp_cycle%0d: v=%0b idx=%0d rk=%h, required v=1 idx=%0d rk=%h",
                 cyc, rk_valid, rk_index, round_key, exp_idx, fips_rk[exp_idx]);
      end
      rdy = pat[cyc % 32];
      rk_ready = rdy;
      step();
      if (rdy) begin
        if (exp_idx == 10) fin = 1'b1;
        else exp_idx++;
      end
    end
    checks++;
    if (fin !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: finished=%0b done=%0b busy=%0b, required 1 1 0", fin, done, busy);
    end
    rk_ready = 1'b0;
    step();
  endtask

  task automatic test_zero_key;
    rk_ready = 1'b0;
    do_start(128'd0);
    checks++;
    if (round_key !== 128'd0 || rk_valid !== 1'b1) begin
      errors++; $display("FAIL zero_rk0: rk=%h v=%0b required 0 1", round_key, rk_valid);
    end
    rk_ready = 1'b1;
    step();
    checks++;
    if (round_key !== zero_rk1 || rk_index !== 4'd1) begin
      errors++;
      $display("FAIL zero_rk1: rk=%h idx=%0d required %h idx=1", round_key, rk_index, zero_rk1);
    end
    go_idle();
  endtask

  task automatic test_abort;
    rk_ready = 1'b1;
    do_start(fips_key);
    repeat (4) step();
    checks++;
    if (rk_index !== 4'd4 || round_key !== fips_rk[4]) begin
      errors++; $display("FAIL abort_pre: idx=%0d required 4", rk_index);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: v=%0b b=%0b d=%0b required 0 0 0", rk_valid, busy, done);
    end
    step();
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: d=%0b v=%0b required 0 0", done, rk_valid);
    end
    abort = 1'b1; start = 1'b1; key_in = fips_key;
    step();
    abort = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL abort_over_start: b=%0b v=%0b required 0 0", busy, rk_valid);
    end
    rk_ready = 1'b0;
    do_start(fips_key);
    checks++;
    if (rk_valid !== 1'b1 || rk_index !== 4'd0 || round_key !== fips_key) begin
      errors++;
      $display("FAIL abort_restart: v=%0b idx=%0d rk=%h required 1 0 %h",
               rk_valid, rk_index, round_key, fips_key);
    end
    go_idle();
  endtask

  task automatic test_start_ignored;
    rk_ready = 1'b1;
    do_start(fips_key);
    repeat (3) step();
    start = 1'b1; key_in = 128'd0;
    step();
    start = 1'b0;
    for (int i = 4; i < 11; i++) begin
      checks++;
      if (round_key !== fips_rk[i] || rk_index !== 4'(i) || rk_valid !== 1'b1) begin
        errors++;
        $display("FAIL ignore_rk%0d: idx=%0d rk=%h required %h", i, rk_index, round_key, fips_rk[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL ignore_done: done=%0b required 1", done);
    end
    rk_ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    rk_ready = 1'b1;
    do_start(fips_key);
    repeat (11) step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: done=%0b required 1", done);
    end
    rk_ready = 1'b0;
    do_start(128'd0);
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b1 || busy !== 1'b1 ||
        rk_index !== 4'd0 || round_key !== 128'd0) begin
      errors++;
      $display("FAIL b2b_restart: d=%0b v=%0b b=%0b idx=%0d rk=%h required 0 1 1 0 0",
               done, rk_valid, busy, rk_index, round_key);
    end
    go_idle();
  endtask

  task automatic test_async_reset;
    rk_ready = 1'b1;
    do_start(fips_key);
    repeat (7) step();
    checks++;
    if (rk_index !== 4'd7) begin
      errors++; $display("FAIL rst_pre: idx=%0d required 7", rk_index);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rk_valid, busy, done, rk_index, round_key, sw_out, rc_index} !== 171'd0) begin
      errors++;
      $display("FAIL async_rst: v=%0b b=%0b d=%0b idx=%0d rk=%h sw=%h, required all zero",
               rk_valid, busy, done, rk_index, round_key, sw_out);
    end
    rk_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_release: d=%0b v=%0b b=%0b required 0 0 0", done, rk_valid, busy);
    end
    do_start(fips_key);
    checks++;
    if (rk_valid !== 1'b1 || rk_index !== 4'd0 || round_key !== fips_key) begin
      errors++;
      $display("FAIL rst_restart: v=%0b idx=%0d rk=%h required 1 0 %h",
               rk_valid, rk_index, round_key, fips_key);
    end
    go_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fips_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    zero_rk1    = 128'h62636363626363636263636362636363;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    test_reset();
    test_fips_ready();
    test_backpressure();
    test_zero_key();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
